fwd_hazard_ctrl: RTL and testbench

//  Parametrised forwarding and load-use hazard controller for the EX stage.

---
 rtl/fwd_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding selector and load-use hazard controller.
// Picks the youngest in-flight writer per operand and stalls/bubbles ID on load-use.
module fwd_hazard_ctrl #(
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int NSTG     = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NSTG-1:0]             stg_wr_en,
    input  logic [NSTG*AW-1:0]          stg_rd_addr,
    input  logic [NRP*AW-1:0]           ex_src_addr,
    output logic [NRP*$clog2(NSTG+1)-1:0] fwd_sel,
    input  logic                        ex_is_load,
    input  logic [AW-1:0]               ex_rd_addr,
    input  logic [NRP*AW-1:0]           id_src_addr,
    input  logic [NRP-1:0]              id_src_used,
    input  logic                        mem_busy,
    output logic                        stall,
    output logic                        bubble,
    output logic [15:0]                 stall_cnt
);

    localparam int SW = $clog2(NSTG+1);
    localparam bit MULTI_BUBBLE = (LOAD_LAT > 1);
    localparam logic [3:0] WAIT_INIT = MULTI_BUBBLE ? 4'(LOAD_LAT - 2) : 4'd0;

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] stall_cnt_reg;
    logic [NRP-1:0] haz_vec;
    logic        haz;

    genvar gi, gk;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_opnd
            logic [NSTG-1:0] match;
            logic [SW-1:0]   sel;

            for (gk = 0; gk < NSTG; gk++) begin : g_stg
                assign match[gk] = stg_wr_en[gk]
                                && (stg_rd_addr[gk*AW +: AW] != '0)
                                && (stg_rd_addr[gk*AW +: AW] == ex_src_addr[gi*AW +: AW]);
            end

            // Scan oldest to youngest so the youngest match overwrites the rest.
            always_comb begin
                sel = '0;
                for (int k = NSTG - 1; k >= 0; k--) begin
                    if (match[k]) sel = SW'(k + 1);
                end
            end

            assign fwd_sel[gi*SW +: SW] = sel;
            assign haz_vec[gi] = id_src_used[gi]
                              && (id_src_addr[gi*AW +: AW] == ex_rd_addr);
        end
    endgenerate

    assign haz = ex_is_load && (ex_rd_addr != '0) && (|haz_vec);

    // Outputs are combinational on state so the stall lands in the hazard cycle itself.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_IDLE: begin
                    stall  = haz || mem_busy;
                    bubble = haz;
                end
                S_WAIT: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                default: begin
                    stall  = 1'b0;
                    bubble = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (haz && MULTI_BUBBLE) begin
                        state_reg <= S_WAIT;
                        cnt_reg   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    // The countdown keeps running under mem_busy; only the exit waits.
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (!mem_busy) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    cnt_reg   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'd0;
        end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3)
// driven by directed vectors; a negedge monitor pops and checks expected values.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  stg_wr_en;
    logic [9:0]  stg_rd_addr;
    logic [9:0]  ex_src_addr;
    logic [3:0]  fwd_sel_a, fwd_sel_b;

    logic        ex_is_load_a, ex_is_load_b;
    logic [4:0]  ex_rd_addr_a, ex_rd_addr_b;
    logic [9:0]  id_src_addr_a, id_src_addr_b;
    logic [1:0]  id_src_used_a, id_src_used_b;
    logic        mem_busy_a, mem_busy_b;
    logic        stall_a, stall_b, bubble_a, bubble_b;
    logic [15:0] stall_cnt_a, stall_cnt_b;

    fwd_hazard_ctrl #(.AW(5), .NRP(2), .NSTG(2), .LOAD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .stg_wr_en(stg_wr_en), .stg_rd_addr(stg_rd_addr), .ex_src_addr(ex_src_addr),
        .fwd_sel(fwd_sel_a),
        .ex_is_load(ex_is_load_a), .ex_rd_addr(ex_rd_addr_a),
        .id_src_addr(id_src_addr_a), .id_src_used(id_src_used_a),
        .mem_busy(mem_busy_a), .stall(stall_a), .bubble(bubble_a), .stall_cnt(stall_cnt_a)
    );

    fwd_hazard_ctrl #(.AW(5), .NRP(2), .NSTG(2), .LOAD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .stg_wr_en(stg_wr_en), .stg_rd_addr(stg_rd_addr), .ex_src_addr(ex_src_addr),
        .fwd_sel(fwd_sel_b),
        .ex_is_load(ex_is_load_b), .ex_rd_addr(ex_rd_addr_b),
        .id_src_addr(id_src_addr_b), .id_src_used(id_src_used_b),
        .mem_busy(mem_busy_b), .stall(stall_b), .bubble(bubble_b), .stall_cnt(stall_cnt_b)
    );

    localparam int K_FWD = 0, K_STALL = 1, K_BUBBLE = 2, K_CNT = 3;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cycle = 0;
    int   tests = 0;
    int   failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] actual(input int d, input int kind);
        logic [15:0] v;
        v = 16'd0;
        case (kind)
            K_FWD:    v = {12'd0, (d == 0) ? fwd_sel_a : fwd_sel_b};
            K_STALL:  v = {15'd0, (d == 0) ? stall_a : stall_b};
            K_BUBBLE: v = {15'd0, (d == 0) ? bubble_a : bubble_b};
            default:  v = (d == 0) ? stall_cnt_a : stall_cnt_b;
        endcase
        return v;
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
            exp_t e;
            logic [15:0] act;
            e = sb_q.pop_front();
            act = actual(e.dut, e.kind);
            tests++;
            if (e.cyc != cycle || act !== e.val) begin
                failed++;
                $display("FAIL %s (dut %0d, cycle %0d): got %0h, expected %0h",
                         e.name, e.dut, cycle, act, e.val);
            end else begin
                $display("[TB] ok   %s (dut %0d, cycle %0d): %0h", e.name, e.dut, cycle, act);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input int kind, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cycle; e.dut = d; e.kind = kind; e.val = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic set_fwd(input logic [1:0] we, input logic [4:0] rd1, input logic [4:0] rd0,
                           input logic [4:0] s1, input logic [4:0] s0);
        stg_wr_en   = we;
        stg_rd_addr = {rd1, rd0};
        ex_src_addr = {s1, s0};
    endtask

    task automatic set_ld(input int d, input logic ld, input logic [4:0] rd,
                          input logic [4:0] i1, input logic [4:0] i0,
                          input logic [1:0] used, input logic busy);
        if (d == 0) begin
            ex_is_load_a = ld; ex_rd_addr_a = rd; id_src_addr_a = {i1, i0};
            id_src_used_a = used; mem_busy_a = busy;
        end else begin
            ex_is_load_b = ld; ex_rd_addr_b = rd; id_src_addr_b = {i1, i0};
            id_src_used_b = used; mem_busy_b = busy;
        end
    endtask

    task automatic clr(input int d);
        set_ld(d, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_fwd(2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        clr(0);
        clr(1);
        mem_busy_a = 1'b1;   // stall must stay forced low while in reset

        // Reset state
        step();
        chk(0, K_STALL, 16'd0, "rst_stall");
        chk(0, K_BUBBLE, 16'd0, "rst_bubble");
        chk(0, K_CNT, 16'd0, "rst_cnt_a");
        chk(1, K_CNT, 16'd0, "rst_cnt_b");
        step();
        rst_n = 1'b1;
        mem_busy_a = 1'b0;

        // Forwarding
        step(); set_fwd(2'b11, 5'd5, 5'd5, 5'd5, 5'd5);
        chk(0, K_FWD, 16'h5, "fwd_youngest_wins");
        chk(1, K_FWD, 16'h5, "fwd_youngest_wins_b");
        step(); set_fwd(2'b10, 5'd0, 5'd0, 5'd0, 5'd0);
        chk(0, K_FWD, 16'h0, "fwd_x0_never");
        step(); set_fwd(2'b10, 5'd7, 5'd7, 5'd7, 5'd9);
        chk(0, K_FWD, 16'h8, "fwd_src1_stage1");
        step(); set_fwd(2'b01, 5'd7, 5'd3, 5'd7, 5'd3);
        chk(0, K_FWD, 16'h1, "fwd_wr_en_gate");
        step(); set_fwd(2'b11, 5'd6, 5'd4, 5'd4, 5'd6);
        chk(0, K_FWD, 16'h6, "fwd_cross");

        // LOAD_LAT=1 single bubble
        step(); set_ld(0, 1'b1, 5'd3, 5'd8, 5'd3, 2'b01, 1'b0);
        chk(0, K_STALL, 16'd1, "lu1_stall");
        chk(0, K_BUBBLE, 16'd1, "lu1_bubble");
        step(); clr(0);
        chk(0, K_STALL, 16'd0, "lu1_stall_end");
        chk(0, K_CNT, 16'd1, "lu1_cnt");
        step(); set_ld(0, 1'b1, 5'd3, 5'd8, 5'd3, 2'b00, 1'b0);
        chk(0, K_STALL, 16'd0, "lu1_unused_src");
        step(); set_ld(0, 1'b1, 5'd3, 5'd3, 5'd8, 2'b10, 1'b0);
        chk(0, K_STALL, 16'd1, "lu1_src1_stall");
        step(); clr(0);
        chk(0, K_CNT, 16'd2, "lu1_cnt2");
        step(); set_ld(0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0);
        chk(0, K_STALL, 16'd0, "lu1_x0_no_haz");
        step(); clr(0);
        chk(0, K_CNT, 16'd2, "lu1_cnt_hold");

        // LOAD_LAT=3: three stall cycles
        step(); set_ld(1, 1'b1, 5'd3, 5'd0, 5'd3, 2'b01, 1'b0);
        chk(1, K_STALL, 16'd1, "lu3_c0_stall");
        chk(1, K_BUBBLE, 16'd1, "lu3_c0_bubble");
        step(); clr(1);
        chk(1, K_STALL, 16'd1, "lu3_c1_stall");
        chk(1, K_BUBBLE, 16'd1, "lu3_c1_bubble");
        step(); chk(1, K_STALL, 16'd1, "lu3_c2_stall");
        step(); chk(1, K_STALL, 16'd0, "lu3_c3_free");
        chk(1, K_CNT, 16'd3, "lu3_cnt");

        // LOAD_LAT=3 with mem_busy for 2 extra WAIT cycles
        step(); set_ld(1, 1'b1, 5'd3, 5'd0, 5'd3, 2'b01, 1'b0);
        chk(1, K_STALL, 16'd1, "busy_c0");
        step(); clr(1);
        chk(1, K_STALL, 16'd1, "busy_c1");
        step(); mem_busy_b = 1'b1;
        chk(1, K_STALL, 16'd1, "busy_c2");
        step(); chk(1, K_STALL, 16'd1, "busy_c3");
        step(); mem_busy_b = 1'b0;
        chk(1, K_STALL, 16'd1, "busy_c4");
        step(); chk(1, K_STALL, 16'd0, "busy_c5_free");
        chk(1, K_CNT, 16'd8, "busy_cnt");

        // mem_busy in IDLE without hazard: freeze but no bubble
        step(); mem_busy_b = 1'b1;
        chk(1, K_STALL, 16'd1, "freeze_stall");
        chk(1, K_BUBBLE, 16'd0, "freeze_no_bubble");
        step(); mem_busy_b = 1'b0;
        chk(1, K_STALL, 16'd0, "freeze_end");
        chk(1, K_CNT, 16'd9, "freeze_cnt");

        // Reset during the second WAIT cycle
        step(); set_ld(1, 1'b1, 5'd3, 5'd0, 5'd3, 2'b01, 1'b0);
        chk(1, K_STALL, 16'd1, "rstw_c0");
        step(); clr(1);
        chk(1, K_STALL, 16'd1, "rstw_c1");
        step(); rst_n = 1'b0;
        chk(1, K_STALL, 16'd0, "rstw_stall_drop");
        chk(1, K_BUBBLE, 16'd0, "rstw_bubble_drop");
        chk(1, K_CNT, 16'd0, "rstw_cnt_clear");
        step(); rst_n = 1'b1;
        chk(1, K_STALL, 16'd0, "rstw_idle");
        chk(0, K_CNT, 16'd0, "rstw_cnt_a_clear");

        // Saturation on the LOAD_LAT=1 instance
        step(); mem_busy_a = 1'b1;
        chk(0, K_STALL, 16'd1, "sat_stall");
        chk(0, K_BUBBLE, 16'd0, "sat_bubble");
        repeat (65533) step();
        step(); mem_busy_a = 1'b0;
        chk(0, K_CNT, 16'hFFFE, "sat_fffe");
        step(); mem_busy_a = 1'b1;
        step();
        chk(0, K_CNT, 16'hFFFF, "sat_reach");
        step();
        chk(0, K_STALL, 16'd1, "sat_stall3");
        step(); mem_busy_a = 1'b0;
        chk(0, K_CNT, 16'hFFFF, "sat_no_wrap");

        step();
        step();
        if (sb_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
